read_command_pool: RTL

Buffers incoming read requests from the AXI front end in arrival order and presents the two oldest to `command_scheduler`. It sits directly upstream of the scheduler's read interface, driving `rready`/`pool_raddr`/`pool_rburst_size`, the lookahead `rready2`/`pool_raddr2`/`pool_rburst_size2`, and `raw`. The head entry is retired when the scheduler pulses `read_issued`.

---
 rtl/type_pkg.sv | 28 ++
 rtl/raw_addr_match.sv | 23 ++
 rtl/read_command_pool.sv | 106 ++++++++++
 3 files changed

// File: rtl/type_pkg.sv
// Shared types for the read path.
//   burst_size_t      - request burst size encoding
//   READ_POOL_DEPTH   - default number of read pool entries
//   dram_addr_t       - 8-bit DRAM address {row[2:0], bank[1:0], col[2:0]}
//   read_pool_entry_t - one buffered read request {address, burst size}
package type_pkg;

  typedef enum logic [1:0] {
    ONE_BYTE    = 2'd0,
    TWO_BYTES   = 2'd1,
    FOUR_BYTES  = 2'd2,
    EIGHT_BYTES = 2'd3
  } burst_size_t;

  localparam int READ_POOL_DEPTH = 8;

  typedef struct packed {
    logic [2:0] row;
    logic [1:0] bank;
    logic [2:0] col;
  } dram_addr_t;

  typedef struct packed {
    dram_addr_t  addr;
    burst_size_t size;
  } read_pool_entry_t;

endpackage

// File: rtl/raw_addr_match.sv
// Compares one address against WDEPTH valid-qualified addresses.
// Ports:
//   i_addr   - address under test
//   i_valid  - per-slot valid flags
//   i_addrs  - slot addresses, slot i at [8i+7:8i]
//   o_hit    - 1 when any valid slot matches i_addr on all 8 bits
module raw_addr_match #(
  parameter int WDEPTH = 4
) (
  input  logic [7:0]          i_addr,
  input  logic [WDEPTH-1:0]   i_valid,
  input  logic [8*WDEPTH-1:0] i_addrs,
  output logic                o_hit
);

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < WDEPTH; i++) begin
      if (i_valid[i] && (i_addrs[8*i +: 8] == i_addr)) o_hit = 1'b1;
    end
  end

endmodule

// File: rtl/read_command_pool.sv
// In-order buffer of AXI read requests; presents the two oldest entries to
// the command scheduler and flags read-after-write hazards on the head.
// Optional feature macro: READ_POOL_RAW_CHECK_EN (hazard comparator; when
// undefined, raw is tied low and the pending-write inputs are unused).
// Ports:
//   clk, n_rst                          - clock, async active-low reset
//   ar_valid/ar_ready/ar_addr/ar_burst_size - request push interface
//   rready/pool_raddr/pool_rburst_size  - head entry
//   rready2/pool_raddr2/pool_rburst_size2 - second-oldest entry
//   read_issued                         - retires the head
//   raw                                 - head matches a pending write
//   wpend_valid/wpend_addr              - pending write slots
module read_command_pool
  import type_pkg::*;
#(
  parameter int DEPTH  = READ_POOL_DEPTH,
  parameter int WDEPTH = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [7:0]          ar_addr,
  input  burst_size_t         ar_burst_size,
  output logic                rready,
  output logic [7:0]          pool_raddr,
  output burst_size_t         pool_rburst_size,
  output logic                rready2,
  output logic [7:0]          pool_raddr2,
  output burst_size_t         pool_rburst_size2,
  input  logic                read_issued,
  output logic                raw,
  input  logic [WDEPTH-1:0]   wpend_valid,
  input  logic [8*WDEPTH-1:0] wpend_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  read_pool_entry_t r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_ptr2;
  read_pool_entry_t w_in_entry;
  read_pool_entry_t w_head;
  read_pool_entry_t w_second;

  // ar_ready looks only at stored count, so a pop in the same cycle
  // cannot open a slot for a push when full.
  assign ar_ready   = (r_count != CW'(DEPTH));
  assign rready     = (r_count != '0);
  assign rready2    = (r_count >= CW'(2));
  assign w_push     = ar_valid && ar_ready;
  assign w_pop      = read_issued && rready;
  assign w_rd_ptr2  = r_rd_ptr + PW'(1);
  assign w_in_entry = '{addr: dram_addr_t'(ar_addr), size: ar_burst_size};
  assign w_head     = r_mem[r_rd_ptr];
  assign w_second   = r_mem[w_rd_ptr2];

  // Storage is not reset; stale contents are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  assign pool_raddr        = rready  ? w_head.addr   : 8'd0;
  assign pool_rburst_size  = rready  ? w_head.size   : ONE_BYTE;
  assign pool_raddr2       = rready2 ? w_second.addr : 8'd0;
  assign pool_rburst_size2 = rready2 ? w_second.size : ONE_BYTE;

`ifdef READ_POOL_RAW_CHECK_EN
  logic w_raw_hit;

  raw_addr_match #(
    .WDEPTH (WDEPTH)
  ) u_raw_addr_match (
    .i_addr  (pool_raddr),
    .i_valid (wpend_valid),
    .i_addrs (wpend_addr),
    .o_hit   (w_raw_hit)
  );

  assign raw = rready && w_raw_hit;
`else
  logic w_unused_wpend;
  assign w_unused_wpend = ^{wpend_valid, wpend_addr};
  assign raw = 1'b0;
`endif

endmodule
